// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency imem read
// port and holds the IF/ID register. Handles stalls (with a one-entry skid
// buffer), taken-branch redirect/flush with in-flight squash, and HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_IF,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] instr_IFID,
  output logic [15:0] next_i_IFID,
  output logic [15:0] pc_IFID,
  output logic        valid_IFID,
  output logic        halted
);

  localparam int unsigned PC_W    = 16;
  localparam int unsigned OP_W    = 4;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);
  localparam logic [OP_W-1:0] OP_HLT  = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e          state_q, state_d, rst_state;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0] next_i_q, next_i_d;
  logic [PC_W-1:0] pc_ifid_q, pc_ifid_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            skid_vld_q, skid_vld_d;
  logic [PC_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;

  logic            accept;
  logic            acc_is_hlt;
  logic            skid_is_hlt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] skid_pc_inc;

  // Request is issued in WAIT, and in FETCH unless decode is stalled
  assign imem_rd_en  = (state_q == S_WAIT) || ((state_q == S_FETCH) && !stall_IF);
  assign imem_addr   = pc_q;
  assign accept      = imem_rd_en && imem_valid;
  assign acc_is_hlt  = (imem_data[PC_W-1 -: OP_W] == OP_HLT);
  assign skid_is_hlt = (skid_instr_q[PC_W-1 -: OP_W] == OP_HLT);
  assign pc_inc      = pc_q + PC_STEP;
  assign skid_pc_inc = skid_pc_q + PC_STEP;

  assign instr_IFID  = instr_q;
  assign next_i_IFID = next_i_q;
  assign pc_IFID     = pc_ifid_q;
  assign valid_IFID  = valid_q;
  assign halted      = halted_q;

  // State after reset: drain a request that is still in flight so its late word is dropped
  always_comb begin
    rst_state = S_FETCH;
    if ((imem_rd_en || (state_q == S_DRAIN)) && !imem_valid) begin
      rst_state = S_DRAIN;
    end
  end

  // Next-state and IF/ID update; branch outranks stall and memory response
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    next_i_d     = next_i_q;
    pc_ifid_d    = pc_ifid_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (branch_taken) begin
      pc_d       = branch_target;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      skid_vld_d = 1'b0;
      halted_d   = 1'b0;
      if (state_q == S_DRAIN) begin
        state_d = imem_valid ? S_FETCH : S_DRAIN;
      end else if (imem_rd_en && !imem_valid) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      unique case (state_q)
        S_FETCH, S_WAIT: begin
          if (accept && stall_IF) begin
            skid_vld_d   = 1'b1;
            skid_instr_d = imem_data;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end else if (accept) begin
            instr_d   = imem_data;
            next_i_d  = pc_inc;
            pc_ifid_d = pc_q;
            valid_d   = 1'b1;
            if (acc_is_hlt) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          end else begin
            state_d = imem_rd_en ? S_WAIT : S_FETCH;
            if (!stall_IF) begin
              valid_d = 1'b0;
              instr_d = NOP_INSTR;
            end
          end
        end
        S_HOLD: begin
          if (!stall_IF) begin
            instr_d    = skid_instr_q;
            next_i_d   = skid_pc_inc;
            pc_ifid_d  = skid_pc_q;
            valid_d    = skid_vld_q;
            skid_vld_d = 1'b0;
            if (skid_is_hlt) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          if (imem_valid) begin
            state_d = S_FETCH;
          end
          if (!stall_IF) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= rst_state;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      next_i_q     <= '0;
      pc_ifid_q    <= '0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      next_i_q     <= next_i_d;
      pc_ifid_q    <= pc_ifid_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a randomized run,
// checked against a program-order stream model and a latency memory model.
module tb_fetch_stage;

  localparam logic [15:0] NOP      = 16'hE001;
  localparam logic [15:0] RST_PC   = 16'h0000;
  localparam logic [15:0] HLT_WORD = 16'hF000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_IF = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] instr_IFID;
  logic [15:0] next_i_IFID;
  logic [15:0] pc_IFID;
  logic        valid_IFID;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  // memory model: fixed_lat >= 0 forces a latency, otherwise random 0..3 extra cycles
  int          fixed_lat = 0;
  int unsigned rand_lat = 0;
  int unsigned lat_eff;
  logic        mem_busy = 1'b0;
  logic [1:0]  mem_cnt = 2'd0;
  logic [15:0] mem_addr_l = 16'h0;
  logic        hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0;

  // stream model
  logic [15:0] exp_pc = RST_PC;
  logic        halted_exp = 1'b0;
  logic        obs_rd_en = 1'b0;
  logic [15:0] obs_addr = 16'h0;
  int          n_deliv = 0;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid),
    .instr_IFID(instr_IFID), .next_i_IFID(next_i_IFID), .pc_IFID(pc_IFID),
    .valid_IFID(valid_IFID), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (hlt_en && (a == hlt_addr)) return HLT_WORD;
    return (a ^ 16'h3C5A) & 16'h7FFF;
  endfunction

  always_comb begin
    lat_eff = (fixed_lat >= 0) ? 32'(fixed_lat) : rand_lat;
    if (mem_busy) imem_valid = (mem_cnt == 2'd0);
    else          imem_valid = imem_rd_en && (lat_eff == 0);
    imem_data = imem_valid ? word_at(mem_busy ? mem_addr_l : imem_addr) : 16'hDEAD;
  end

  always @(posedge clk) begin
    rand_lat <= $urandom_range(3, 0);
    if (mem_busy) begin
      if (mem_cnt == 2'd0) mem_busy <= 1'b0;
      else                 mem_cnt  <= mem_cnt - 2'd1;
    end else if (imem_rd_en && !imem_valid) begin
      mem_busy   <= 1'b1;
      mem_addr_l <= imem_addr;
      mem_cnt    <= 2'(lat_eff - 1);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // one clock: drive at negedge, check request side, then check IF/ID after the edge
  task automatic cycle(input logic s, input logic b, input logic [15:0] t, input logic r);
    logic [15:0] p_instr, p_next, p_pc, w;
    logic        p_valid;
    stall_IF = s; branch_taken = b; branch_target = t; rst = r;
    #1;
    obs_rd_en = imem_rd_en;
    obs_addr  = imem_addr;
    if (!r) begin
      if (imem_rd_en) chk("req_addr", imem_addr, exp_pc);
      if (halted_exp) chk("halt_no_req", 16'(imem_rd_en), 16'h0);
      else if (s && !mem_busy) chk("stall_no_req", 16'(imem_rd_en), 16'h0);
    end
    p_instr = instr_IFID; p_next = next_i_IFID; p_pc = pc_IFID; p_valid = valid_IFID;
    @(posedge clk);
    #1;
    if (r) begin
      chk("rst_valid", 16'(valid_IFID), 16'h0);
      chk("rst_instr", instr_IFID, NOP);
      chk("rst_pc", pc_IFID, 16'h0);
      chk("rst_next_i", next_i_IFID, 16'h0);
      exp_pc = RST_PC;
      halted_exp = 1'b0;
    end else if (b) begin
      chk("flush_valid", 16'(valid_IFID), 16'h0);
      chk("flush_instr", instr_IFID, NOP);
      exp_pc = t;
      halted_exp = 1'b0;
    end else if (s || halted_exp) begin
      chk("hold_instr", instr_IFID, p_instr);
      chk("hold_next_i", next_i_IFID, p_next);
      chk("hold_pc", pc_IFID, p_pc);
      chk("hold_valid", 16'(valid_IFID), 16'(p_valid));
    end else if (valid_IFID) begin
      w = word_at(exp_pc);
      chk("dlv_pc", pc_IFID, exp_pc);
      chk("dlv_instr", instr_IFID, w);
      chk("dlv_next_i", next_i_IFID, exp_pc + 16'd2);
      n_deliv++;
      if (w[15:12] == 4'hF) halted_exp = 1'b1;
      else                  exp_pc = exp_pc + 16'd2;
    end else begin
      chk("bubble_instr", instr_IFID, NOP);
    end
    chk("halted", 16'(halted), 16'(halted_exp));
    @(negedge clk);
  endtask

  task automatic run_until_valid(input string tag, input int max);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      if (valid_IFID) done = 1'b1;
    end
    chk(tag, 16'(done), 16'h1);
  endtask

  task automatic run_until_req(input string tag, input int max);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      if (obs_rd_en) done = 1'b1;
    end
    chk(tag, 16'(done), 16'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fixed_lat = 0;
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);

    // zero-latency memory: one instruction per cycle
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      chk("t1_valid", 16'(valid_IFID), 16'h1);
      chk("t1_next_i", next_i_IFID, 16'(2 * (i + 1)));
      chk("t1_instr", instr_IFID, word_at(16'(2 * i)));
    end

    // 3-cycle memory: address held, two bubbles, then the word
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    fixed_lat = 2;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      chk("t2_addr", obs_addr, 16'h0000);
      chk("t2_rd_en", 16'(obs_rd_en), 16'h1);
      chk("t2_valid", 16'(valid_IFID), 16'(i == 2));
    end
    chk("t2_next_i", next_i_IFID, 16'h0002);

    // stall while the response returns: word parked, delivered once stall drops
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t3_valid", 16'(valid_IFID), 16'h1);
    chk("t3_pc", pc_IFID, 16'h0002);
    chk("t3_instr", instr_IFID, word_at(16'h0002));
    run_until_valid("t3_next_wait", 6);
    chk("t3_next_pc", pc_IFID, 16'h0004);

    // branch while waiting: flush, drop late word, refetch at target
    fixed_lat = 3;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0040, 1'b0);
    chk("t4_flush_valid", 16'(valid_IFID), 16'h0);
    run_until_req("t4_req_wait", 8);
    chk("t4_addr", obs_addr, 16'h0040);
    run_until_valid("t4_dlv_wait", 8);
    chk("t4_pc", pc_IFID, 16'h0040);

    // HLT at 0x0010, then redirect to 0x0020
    fixed_lat = 0;
    hlt_en = 1'b1;
    hlt_addr = 16'h0010;
    cycle(1'b0, 1'b1, 16'h0010, 1'b0);
    run_until_valid("t5_hlt_wait", 4);
    chk("t5_instr", instr_IFID, HLT_WORD);
    chk("t5_halted", 16'(halted), 16'h1);
    chk("t5_pc", pc_IFID, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      chk("t5_no_req", 16'(obs_rd_en), 16'h0);
      chk("t5_keep", instr_IFID, HLT_WORD);
    end
    cycle(1'b0, 1'b1, 16'h0020, 1'b0);
    chk("t5_unhalt", 16'(halted), 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t5_resume_rd_en", 16'(obs_rd_en), 16'h1);
    chk("t5_resume_addr", obs_addr, 16'h0020);
    hlt_en = 1'b0;

    // PC wrap at the top of the address space
    cycle(1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_until_valid("t6_wait", 4);
    chk("t6_pc", pc_IFID, 16'hFFFE);
    chk("t6_next_i", next_i_IFID, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t6_addr", obs_addr, 16'h0000);

    // reset while a request is outstanding: stale word must not land in IF/ID
    fixed_lat = 3;
    cycle(1'b0, 1'b1, 16'h0100, 1'b0);
    run_until_req("t7_req_wait", 8);
    chk("t7_addr", obs_addr, 16'h0100);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    run_until_req("t7_req2_wait", 8);
    chk("t7_addr_rst", obs_addr, RST_PC);
    run_until_valid("t7_dlv_wait", 8);
    chk("t7_pc", pc_IFID, RST_PC);
    chk("t7_instr", instr_IFID, word_at(RST_PC));

    // randomized latency, stalls, branches and resets
    fixed_lat = -1;
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(3, 0) == 0),
            1'($urandom_range(29, 0) == 0),
            16'($urandom) & 16'hFFFE,
            1'($urandom_range(199, 0) == 0));
    end
    chk("rand_progress", 16'(n_deliv > 300), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
